// File: rtl/lt24_lcd_reset_sequencer.sv
// Timed LT24 panel reset driven from the LCD_RESET_N PIO: deglitch, minimum low pulse, recovery delay.
// Optional macro LT24_RST_COUNT_EN adds rst_count, a saturating count of PIO-requested panel resets.
`timescale 1ns/1ps
module lt24_lcd_reset_sequencer #(
    parameter int LOW_CYCLES      = 500,
    parameter int RECOVERY_CYCLES = 6000000,
    parameter int FILTER_CYCLES   = 4,
    parameter int CNT_W           = 23
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pio_rst_n,
    output logic       lcd_reset_n,
    output logic       lcd_ready,
`ifdef LT24_RST_COUNT_EN
    output logic [7:0] rst_count,
`endif
    output logic       busy
);

    localparam int FCNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  LOW_MAX   = CNT_W'(LOW_CYCLES);
    localparam logic [CNT_W-1:0]  REC_LAST  = CNT_W'(RECOVERY_CYCLES - 1);
    localparam logic [FCNT_W-1:0] FILT_LAST = FCNT_W'(FILTER_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RECOVER = 2'd1,
        ST_READY   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sample_q;
    logic              filt_q, filt_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              lcd_reset_n_q, lcd_reset_n_d;
    logic              lcd_ready_q, lcd_ready_d;
    logic              busy_q, busy_d;
`ifdef LT24_RST_COUNT_EN
    logic [7:0]        rst_count_q, rst_count_d;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_ASSERT;
            cnt_q         <= '0;
            sample_q      <= 1'b0;
            filt_q        <= 1'b0;
            fcnt_q        <= '0;
            lcd_reset_n_q <= 1'b0;
            lcd_ready_q   <= 1'b0;
            busy_q        <= 1'b1;
`ifdef LT24_RST_COUNT_EN
            rst_count_q   <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sample_q      <= pio_rst_n;
            filt_q        <= filt_d;
            fcnt_q        <= fcnt_d;
            lcd_reset_n_q <= lcd_reset_n_d;
            lcd_ready_q   <= lcd_ready_d;
            busy_q        <= busy_d;
`ifdef LT24_RST_COUNT_EN
            rst_count_q   <= rst_count_d;
`endif
        end
    end

    // The filtered level only moves after FILTER_CYCLES consecutive disagreeing samples.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = fcnt_q;
        if (sample_q == filt_q) begin
            fcnt_d = '0;
        end else if (fcnt_q == FILT_LAST) begin
            filt_d = sample_q;
            fcnt_d = '0;
        end else begin
            fcnt_d = fcnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_ASSERT: begin
                if (cnt_q == LOW_MAX && filt_q) begin
                    state_d = ST_RECOVER;
                    cnt_d   = '0;
                end else if (cnt_q != LOW_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RECOVER: begin
                // A new reset request wins over recovery completing in the same cycle.
                if (!filt_q) begin
                    state_d = ST_ASSERT;
                    cnt_d   = '0;
                end else if (cnt_q == REC_LAST) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_READY: begin
                cnt_d = '0;
                if (!filt_q) begin
                    state_d = ST_ASSERT;
                end
            end
            default: begin
                state_d = ST_ASSERT;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change together with it.
    always_comb begin
        lcd_reset_n_d = (state_d != ST_ASSERT);
        lcd_ready_d   = (state_d == ST_READY);
        busy_d        = (state_d != ST_READY);
`ifdef LT24_RST_COUNT_EN
        rst_count_d   = rst_count_q;
        if (state_d == ST_ASSERT && state_q != ST_ASSERT && rst_count_q != 8'hFF) begin
            rst_count_d = rst_count_q + 8'd1;
        end
`endif
    end

    assign lcd_reset_n = lcd_reset_n_q;
    assign lcd_ready   = lcd_ready_q;
    assign busy        = busy_q;
`ifdef LT24_RST_COUNT_EN
    assign rst_count   = rst_count_q;
`endif

endmodule

// File: tb/tb_lt24_lcd_reset_sequencer.sv
// Self-checking bench for lt24_lcd_reset_sequencer (LOW=8, RECOVERY=20, FILTER=3).
// Define LT24_RST_COUNT_EN to also exercise the rst_count diagnostic counter.
`timescale 1ns/1ps
module tb_lt24_lcd_reset_sequencer;

    localparam int LOW  = 8;
    localparam int REC  = 20;
    localparam int FILT = 3;

    logic clk       = 1'b0;
    logic reset_n   = 1'b1;
    logic pio_rst_n = 1'b0;
    logic lcd_reset_n;
    logic lcd_ready;
    logic busy;
`ifdef LT24_RST_COUNT_EN
    logic [7:0] rst_count;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic  pio;
        int    reps;
        logic  er;
        logic  ey;
        logic  eb;
        string name;
    } vec_t;

    typedef struct {
        logic  er;
        logic  ey;
        logic  eb;
        string name;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    lt24_lcd_reset_sequencer #(
        .LOW_CYCLES(LOW),
        .RECOVERY_CYCLES(REC),
        .FILTER_CYCLES(FILT),
        .CNT_W(23)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .pio_rst_n(pio_rst_n),
        .lcd_reset_n(lcd_reset_n),
        .lcd_ready(lcd_ready),
`ifdef LT24_RST_COUNT_EN
        .rst_count(rst_count),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Drive one clock of stimulus, queue its expected outputs, compare after the edge.
    task automatic step(input logic pio, input logic er, input logic ey, input logic eb,
                        input string name);
        exp_t e;
        @(negedge clk);
        pio_rst_n = pio;
        e.er = er;
        e.ey = ey;
        e.eb = eb;
        e.name = name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check(e.name, {5'd0, lcd_reset_n, lcd_ready, busy}, {5'd0, e.er, e.ey, e.eb});
    endtask

    task automatic tick(input logic pio);
        @(negedge clk);
        pio_rst_n = pio;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic pio, input int reps, input logic er, input logic ey,
                       input logic eb, input string name);
        vec_t v;
        v.pio = pio;
        v.reps = reps;
        v.er = er;
        v.ey = ey;
        v.eb = eb;
        v.name = name;
        tbl.push_back(v);
    endtask

    task automatic run_table();
        foreach (tbl[i]) begin
            for (int r = 0; r < tbl[i].reps; r++) begin
                step(tbl[i].pio, tbl[i].er, tbl[i].ey, tbl[i].eb, tbl[i].name);
            end
        end
        tbl.delete();
    endtask

    // With pio held high, count remaining low clocks until lcd_reset_n rises (bounded).
    task automatic measure_low(input string name, input int start);
        int low;
        low = start;
        for (int i = 0; i < 40; i++) begin
            tick(1'b1);
            if (lcd_reset_n) break;
            low++;
        end
        check_range(name, low, LOW, LOW + 1);
        check({name, "_rise_state"}, {5'd0, lcd_reset_n, lcd_ready, busy}, 8'b101);
    endtask

    task automatic complete_recovery(input string name);
        for (int i = 0; i < REC - 1; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b1, {name, "_recover"});
        end
        step(1'b1, 1'b1, 1'b1, 1'b0, {name, "_ready"});
    endtask

    // From READY: a 4-clock low request, checked fall latency and low width; ends at the rise.
    task automatic pulse_from_ready(input string name);
        for (int i = 0; i < FILT + 1; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, {name, "_hold"});
        end
        step(1'b1, 1'b0, 1'b0, 1'b1, {name, "_fall"});
        measure_low({name, "_low_width"}, 1);
    endtask

    initial begin
        #1;
        reset_n = 1'b0;
        #1;
        check("reset_state", {5'd0, lcd_reset_n, lcd_ready, busy}, 8'b001);
`ifdef LT24_RST_COUNT_EN
        check("reset_rst_count", rst_count, 8'd0);
`endif
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Power-up hold with a short high glitch, release, recovery, and glitches in RECOVER/READY.
        add(1'b0, 10, 1'b0, 1'b0, 1'b1, "powerup_hold");
        add(1'b1, 2,  1'b0, 1'b0, 1'b1, "glitch_assert");
        add(1'b0, 18, 1'b0, 1'b0, 1'b1, "powerup_hold2");
        add(1'b1, FILT + 1, 1'b0, 1'b0, 1'b1, "release_filter");
        add(1'b1, 5,  1'b1, 1'b0, 1'b1, "recover_a");
        add(1'b0, 2,  1'b1, 1'b0, 1'b1, "glitch_recover");
        add(1'b1, REC - 7, 1'b1, 1'b0, 1'b1, "recover_b");
        add(1'b1, 4,  1'b1, 1'b1, 1'b0, "ready");
        add(1'b0, 2,  1'b1, 1'b1, 1'b0, "glitch_ready");
        add(1'b1, 6,  1'b1, 1'b1, 1'b0, "after_glitch");
        run_table();

        pulse_from_ready("pulse4");
        complete_recovery("pulse4");

        pulse_from_ready("pre_abort");
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 1'b1, "recover_to_10");
        for (int i = 0; i < FILT + 1; i++) step(1'b0, 1'b1, 1'b0, 1'b1, "abort_hold");
        step(1'b0, 1'b0, 1'b0, 1'b1, "abort_fall");
        measure_low("abort_low_width", 1);
        complete_recovery("abort");

        pulse_from_ready("pre_reset");
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b1, "recover_before_reset");
`ifdef LT24_RST_COUNT_EN
        check("rst_count_four_entries", rst_count, 8'd4);
`endif
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_mid_recover", {5'd0, lcd_reset_n, lcd_ready, busy}, 8'b001);
`ifdef LT24_RST_COUNT_EN
        check("async_reset_rst_count", rst_count, 8'd0);
`endif
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        add(1'b1, LOW, 1'b0, 1'b0, 1'b1, "restart_assert");
        add(1'b1, REC, 1'b1, 1'b0, 1'b1, "restart_recover");
        add(1'b1, 2,   1'b1, 1'b1, 1'b0, "restart_ready");
        run_table();

`ifdef LT24_RST_COUNT_EN
        check("rst_count_no_incr_on_reset", rst_count, 8'd0);
        for (int p = 0; p < 260; p++) begin
            repeat (FILT + 1) tick(1'b0);
            repeat (14) tick(1'b1);
            if (p == 0) check("rst_count_first", rst_count, 8'd1);
        end
        check("rst_count_saturated", rst_count, 8'd255);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_count_cleared", rst_count, 8'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (12) tick(1'b1);
        check("rst_count_after_restart", rst_count, 8'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
